// File: rtl/tb_pkg.sv
// Shared definitions for the I2C register-transaction master.
//   i2c_txn_state_t : master FSM state encoding
//   i2c_byte_kind_t : which byte of the transaction is on the wire
//   I2C_RW_WRITE / I2C_RW_READ : values of the rw command input
package tb_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_START  = 4'd1,
        ST_TX_BIT = 4'd2,
        ST_TX_ACK = 4'd3,
        ST_RSTART = 4'd4,
        ST_RX_BIT = 4'd5,
        ST_RX_ACK = 4'd6,
        ST_STOP   = 4'd7,
        ST_DONE   = 4'd8
    } i2c_txn_state_t;

    typedef enum logic [1:0] {
        BK_ADDR_W = 2'd0,
        BK_REG    = 2'd1,
        BK_DATA   = 2'd2,
        BK_ADDR_R = 2'd3
    } i2c_byte_kind_t;

    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_phase_timer.sv
// SCL quarter-phase generator.
//   clk, rst_n  : clock, synchronous active-low reset
//   i_en        : count while high; held at quarter 0 / count 0 while low
//   o_quarter   : current quarter of the bit period (0..3)
//   o_tick      : high on the last clk cycle of each quarter
module i2c_phase_timer #(
    parameter int CLK_DIV = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    output logic [1:0] o_quarter,
    output logic       o_tick
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_quarter;
    logic          w_last;

    assign w_last    = (r_cnt == CW'(CLK_DIV - 1));
    assign o_tick    = i_en && w_last;
    assign o_quarter = r_quarter;

    always_ff @(posedge clk) begin
        if (!rst_n || !i_en) begin
            r_cnt     <= '0;
            r_quarter <= 2'd0;
        end else if (w_last) begin
            r_cnt     <= '0;
            r_quarter <= r_quarter + 2'd1;
        end else begin
            r_cnt     <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/i2c_txn_master.sv
// I2C master executing one register write or register read per start strobe.
//   clk, rst_n        : clock, synchronous active-low reset
//   start             : command strobe, accepted only when idle
//   slave_addr, rw, reg_addr, wdata, num_bytes : command, latched on start
//   busy, done, ack   : status; ack is valid with the done pulse
//   rdata             : read bytes, byte n at [8n+7:8n]
//   scl_oe, sda_oe    : open-drain pull-down enables
//   sda_i             : resolved SDA line
module i2c_txn_master
    import tb_pkg::*;
#(
    parameter int CLK_DIV   = 25,
    parameter int MAX_BYTES = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [6:0]             slave_addr,
    input  logic                   rw,
    input  logic [7:0]             reg_addr,
    input  logic [8*MAX_BYTES-1:0] wdata,
    input  logic [3:0]             num_bytes,
    output logic                   busy,
    output logic                   done,
    output logic                   ack,
    output logic [8*MAX_BYTES-1:0] rdata,
    output logic                   scl_oe,
    output logic                   sda_oe,
    input  logic                   sda_i
);

    localparam int BCW = $clog2(MAX_BYTES + 1);
    localparam int IW  = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

    i2c_txn_state_t               r_state;
    i2c_byte_kind_t               r_kind;
    logic [7:0]                   r_shift;
    logic [2:0]                   r_bit_cnt;
    logic [BCW-1:0]               r_byte_cnt;
    logic [BCW-1:0]               r_n;
    logic                         r_rw;
    logic [6:0]                   r_addr;
    logic [7:0]                   r_reg;
    logic [MAX_BYTES-1:0][7:0]    r_wdata;
    logic [MAX_BYTES-1:0][7:0]    r_rdata;
    logic                         r_ack;
    logic                         r_nack;

    logic [1:0]     w_q;
    logic           w_tick;
    logic           w_busy;
    logic           w_sample;
    logic           w_bit_end;
    logic [BCW-1:0] w_next_cnt;
    logic           w_last;
    logic [BCW-1:0] w_n_clamp;
    logic           w_scl_oe;
    logic           w_sda_oe;

    assign w_busy     = (r_state != ST_IDLE);
    assign w_sample   = w_tick && (w_q == 2'd2);
    assign w_bit_end  = w_tick && (w_q == 2'd3);
    assign w_next_cnt = r_byte_cnt + BCW'(1);
    assign w_last     = (w_next_cnt == r_n);

    i2c_phase_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (w_busy),
        .o_quarter (w_q),
        .o_tick    (w_tick)
    );

    // Byte count clamp; a read always transfers at least one byte.
    always_comb begin
        w_n_clamp = BCW'(num_bytes);
        if (32'(num_bytes) > MAX_BYTES)
            w_n_clamp = BCW'(MAX_BYTES);
        if (rw == I2C_RW_READ && w_n_clamp == '0)
            w_n_clamp = BCW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_kind     <= BK_ADDR_W;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_n        <= '0;
            r_rw       <= I2C_RW_WRITE;
            r_addr     <= '0;
            r_reg      <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_ack      <= 1'b0;
            r_nack     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (start) begin
                    r_state    <= ST_START;
                    r_rw       <= rw;
                    r_addr     <= slave_addr;
                    r_reg      <= reg_addr;
                    r_wdata    <= wdata;
                    r_n        <= w_n_clamp;
                    r_shift    <= {slave_addr, 1'b0};
                    r_kind     <= BK_ADDR_W;
                    r_bit_cnt  <= '0;
                    r_byte_cnt <= '0;
                    r_ack      <= 1'b1;
                end
                ST_START: if (w_bit_end) r_state <= ST_TX_BIT;
                ST_TX_BIT: if (w_bit_end) begin
                    r_shift   <= {r_shift[6:0], 1'b0};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) r_state <= ST_TX_ACK;
                end
                ST_TX_ACK: begin
                    if (w_sample) r_nack <= sda_i;
                    if (w_bit_end) begin
                        if (r_nack) begin
                            r_ack   <= 1'b0;
                            r_state <= ST_STOP;
                        end else begin
                            case (r_kind)
                                BK_ADDR_W: begin
                                    r_shift <= r_reg;
                                    r_kind  <= BK_REG;
                                    r_state <= ST_TX_BIT;
                                end
                                BK_REG: begin
                                    if (r_rw == I2C_RW_READ) begin
                                        r_state <= ST_RSTART;
                                    end else if (r_n == '0) begin
                                        r_state <= ST_STOP;
                                    end else begin
                                        r_shift    <= r_wdata[0];
                                        r_kind     <= BK_DATA;
                                        r_byte_cnt <= '0;
                                        r_state    <= ST_TX_BIT;
                                    end
                                end
                                BK_DATA: begin
                                    if (w_last) begin
                                        r_state <= ST_STOP;
                                    end else begin
                                        r_byte_cnt <= w_next_cnt;
                                        r_shift    <= r_wdata[IW'(w_next_cnt)];
                                        r_state    <= ST_TX_BIT;
                                    end
                                end
                                default: begin
                                    r_byte_cnt <= '0;
                                    r_state    <= ST_RX_BIT;
                                end
                            endcase
                        end
                    end
                end
                // Extra SCL pulse with SDA released, then START drops SDA
                // under a high SCL to form the repeated start.
                ST_RSTART: if (w_bit_end) begin
                    r_shift <= {r_addr, 1'b1};
                    r_kind  <= BK_ADDR_R;
                    r_state <= ST_START;
                end
                ST_RX_BIT: begin
                    if (w_sample) r_shift <= {r_shift[6:0], sda_i};
                    if (w_bit_end) begin
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_rdata[IW'(r_byte_cnt)] <= r_shift;
                            r_state                  <= ST_RX_ACK;
                        end
                    end
                end
                ST_RX_ACK: if (w_bit_end) begin
                    if (w_last) begin
                        r_state <= ST_STOP;
                    end else begin
                        r_byte_cnt <= w_next_cnt;
                        r_state    <= ST_RX_BIT;
                    end
                end
                ST_STOP: if (w_bit_end) r_state <= ST_DONE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Line drive per quarter. SCL is low in quarters 0-1 of a bit; STOP
    // releases SCL after quarter 0 and SDA from quarter 2, leaving two
    // idle quarters before DONE.
    always_comb begin
        w_scl_oe = 1'b0;
        w_sda_oe = 1'b0;
        case (r_state)
            ST_START:  w_sda_oe = w_q[1];
            ST_TX_BIT: begin
                w_scl_oe = ~w_q[1];
                w_sda_oe = ~r_shift[7];
            end
            ST_TX_ACK, ST_RSTART, ST_RX_BIT: w_scl_oe = ~w_q[1];
            ST_RX_ACK: begin
                w_scl_oe = ~w_q[1];
                w_sda_oe = ~w_last;
            end
            ST_STOP: begin
                w_scl_oe = (w_q == 2'd0);
                w_sda_oe = ~w_q[1];
            end
            default: ;
        endcase
    end

    assign scl_oe = w_scl_oe;
    assign sda_oe = w_sda_oe;
    assign busy   = w_busy;
    assign done   = (r_state == ST_DONE);
    assign ack    = r_ack;
    assign rdata  = r_rdata;

endmodule

// File: doc/i2c_txn_master.md
I2C_TXN_MASTER -- requirements
Module: i2c_txn_master

Interface
REQ-001 Parameter CLK_DIV, default 25, clk cycles per SCL quarter-period (bit period = 4*CLK_DIV); legal range 2..1023.
REQ-002 Parameter MAX_BYTES, default 8, maximum data bytes per transaction.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst_n  in  1  synchronous, active-low reset.
REQ-005 start  in  1  one-cycle command strobe; sampled only in IDLE.
REQ-006 slave_addr  in  7  target device address.
REQ-007 rw  in  1  0 = register write, 1 = register read.
REQ-008 reg_addr  in  8  register address byte.
REQ-009 wdata  in  8*MAX_BYTES  write bytes; byte n at bits [8n+7:8n].
REQ-010 num_bytes  in  4  data byte count.
REQ-011 busy  out  1  high from the cycle after accepted start until done.
REQ-012 done  out  1  one-cycle pulse at transaction end.
REQ-013 ack  out  1  valid with done; 1 = every master-sent byte was ACKed.
REQ-014 rdata  out  8*MAX_BYTES  read bytes, same packing as wdata.
REQ-015 scl_oe  out  1  1 = pull SCL low (open drain).
REQ-016 sda_oe  out  1  1 = pull SDA low (open drain).
REQ-017 sda_i  in  1  resolved SDA line.

Function
REQ-018 start in IDLE latches all command inputs; start outside IDLE is ignored, no side effects.
REQ-019 num_bytes >MAX_BYTES clamps to MAX_BYTES; 0 on write = pointer-only write; 0 on read treated as 1.
REQ-020 Write sequence: START, {slave_addr,0}, reg_addr, wdata bytes 0..N-1 (MSB first), STOP.
REQ-021 Read sequence: START, {slave_addr,0}, reg_addr, repeated START, {slave_addr,1}, N read bytes, STOP; master ACKs bytes 0..N-2, NACKs byte N-1.
REQ-022 FSM states: IDLE, START, TX_BIT, TX_ACK, RSTART, RX_BIT, RX_ACK, STOP, DONE; DONE lasts one cycle, then IDLE.
REQ-023 SDA changes only while SCL low (quarter 0); SCL high in quarters 2-3; sda_i sampled at end of quarter 2 (ACK and RX bits).
REQ-024 START/RSTART: SDA falls while SCL high, held CLK_DIV*2 cycles; STOP: SDA rises while SCL high, then bus idle CLK_DIV*2 cycles before DONE.
REQ-025 NACK (sda_i=1) on any master-sent byte aborts to STOP; ack=0; remaining bytes not sent; rdata unchanged from prior contents for unread bytes.
REQ-026 rdata byte n updated only at completion of its 8th bit; bytes beyond N retain previous values.
REQ-027 Bit/byte counters: 3-bit bit counter wraps 7->0 at byte end; byte counter compares against clamped N, no overflow past MAX_BYTES.
REQ-028 No clock stretching support; SCL is free-running per CLK_DIV while busy.

Reset
REQ-029 rst_n=0 at any clock edge forces IDLE: busy=0, done=0, ack=0, rdata=0, scl_oe=0, sda_oe=0, counters=0.
REQ-030 Reset mid-transaction releases both lines immediately (no STOP generated); no done pulse.
REQ-031 First start is accepted on the first edge with rst_n=1.

Structure
REQ-032 State enum i2c_txn_state_t and I2C_RW_WRITE/I2C_RW_READ constants live in shared package tb_pkg.
REQ-033 One sub-module i2c_phase_timer: CLK_DIV counter emitting quarter-phase index (0..3) and phase-tick strobe; enabled only while busy.

Verification (CLK_DIV=4, MAX_BYTES=8, bench slave model on bus)
REQ-034 Write slave 0x42, reg 0x10, N=1, wdata[7:0]=0xA5 -> bus bytes 0x84,0x10,0xA5 all ACKed, STOP, done with ack=1, busy low next cycle.
REQ-035 Read slave 0x42, reg 0x20, N=2, slave returns 0x3C,0xC3 -> bytes 0x84,0x20, Sr, 0x85; rdata[7:0]=0x3C, rdata[15:8]=0xC3; master ACK then NACK; ack=1.
REQ-036 Address 0x55 with no slave responding -> NACK on 0xAA, immediate STOP, done with ack=0, no reg byte on bus.
REQ-037 start re-pulsed while busy, and num_bytes=12 write -> second start ignored, exactly 8 data bytes sent.
REQ-038 rst_n low mid-byte of a write -> next edge scl_oe=0, sda_oe=0, busy=0, no done; fresh write afterwards completes correctly.
